recirc_mux_rx_mc: RTL and testbench

- Single-clock receive side of a multi-channel recirculation-mux link. Each of g_channels remote sources signals a new word by flipping a toggle line and holding its data bus stable.
- The block synchronises each toggle, detects the edge and captures the word through a recirculating hold register. A round-robin arbiter then serialises the captured words onto one valid/ready stream tagged with a channel id.
- Per-channel sticky overrun flags report words that were overwritten before being read.

---
 rtl/recirc_mux_pkg.sv | 11 +
 rtl/sync_edge_det.sv | 28 ++
 rtl/recirc_mux_rx_mc.sv | 133 +++++++++++++
 tb/tb_recirc_mux_rx_mc.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/recirc_mux_pkg.sv
// Shared constants and helpers for the recirculation-mux receive block.
package recirc_mux_pkg;

    // Cycles beyond the sync depth that the arm counter waits before enabling edge detection
    localparam int ARM_EXTRA = 1;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Per-channel toggle synchroniser with a prev flop; emits a one-cycle pulse on
// any change of the synchronised toggle once the top level has armed detection.
module sync_edge_det #(
    parameter int g_stages = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_toggle,
    input  logic i_armed,
    output logic o_pulse
);

    logic [g_stages-1:0] sync_reg;
    logic                prev_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[g_stages-2:0], i_toggle};
            prev_reg <= sync_reg[g_stages-1];
        end
    end

    assign o_pulse = i_armed & (sync_reg[g_stages-1] ^ prev_reg);

endmodule

// File: rtl/recirc_mux_rx_mc.sv
// Multi-channel recirculation-mux receiver: captures each channel's word on a
// synchronised toggle edge and serialises captured words round-robin onto one stream.
module recirc_mux_rx_mc
    import recirc_mux_pkg::*;
#(
    parameter int g_stages   = 2,
    parameter int g_width    = 8,
    parameter int g_channels = 4,
    localparam int CH_W      = ch_width(g_channels)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [g_channels-1:0]         i_toggle,
    input  logic [g_channels*g_width-1:0] i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [g_width-1:0]            o_data,
    output logic [CH_W-1:0]               o_ch,
    output logic [g_channels-1:0]         o_pending,
    output logic [g_channels-1:0]         o_overrun,
    input  logic [g_channels-1:0]         i_overrun_clr,
    output logic                          o_armed
);

    localparam int ARM_N = g_stages + ARM_EXTRA;
    localparam int ARM_W = $clog2(ARM_N + 1);

    logic [ARM_W-1:0]      arm_cnt_reg;
    logic                  armed_reg;
    logic [g_channels-1:0] pulse;
    logic [g_channels-1:0] clr;
    logic [g_channels-1:0] ovr_set;
    logic [g_channels-1:0] pending_reg, pending_next;
    logic [g_channels-1:0] overrun_reg, overrun_next;
    logic [g_width-1:0]    hold_reg [g_channels];
    logic [CH_W-1:0]       ptr_reg;
    logic [CH_W-1:0]       grant_idx;
    logic                  grant_found;
    logic                  load;
    logic                  valid_reg;
    logic [g_width-1:0]    data_reg;
    logic [CH_W-1:0]       ch_reg;

    // Prev flops settle on the synchronised toggle level before detection is enabled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            arm_cnt_reg <= '0;
            armed_reg   <= 1'b0;
        end else if (!armed_reg) begin
            if (arm_cnt_reg == ARM_W'(ARM_N))
                armed_reg <= 1'b1;
            else
                arm_cnt_reg <= arm_cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < g_channels; gi++) begin : g_ch
            sync_edge_det #(
                .g_stages(g_stages)
            ) u_sync (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_toggle (i_toggle[gi]),
                .i_armed  (armed_reg),
                .o_pulse  (pulse[gi])
            );

            assign clr[gi]     = load && (grant_idx == CH_W'(gi));
            assign ovr_set[gi] = pulse[gi] && pending_reg[gi] && !clr[gi];

            // Recirculating hold: latest captured word wins
            always_ff @(posedge i_clk) begin
                if (i_rst)
                    hold_reg[gi] <= '0;
                else if (pulse[gi])
                    hold_reg[gi] <= i_data[gi*g_width +: g_width];
            end
        end
    endgenerate

    always_comb begin
        pending_next = (pending_reg & ~clr) | pulse;
        overrun_next = (overrun_reg & ~i_overrun_clr) | ovr_set;
    end

    // Round-robin search starting just above the last granted channel
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 1; k <= g_channels; k++) begin
            idx = (int'(ptr_reg) + k) % g_channels;
            if (!grant_found && pending_reg[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
    end

    assign load = (!valid_reg || i_ready) && grant_found;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_reg <= '0;
            overrun_reg <= '0;
            ptr_reg     <= CH_W'(g_channels - 1);
            valid_reg   <= 1'b0;
            data_reg    <= '0;
            ch_reg      <= '0;
        end else begin
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
            if (load) begin
                valid_reg <= 1'b1;
                data_reg  <= hold_reg[grant_idx];
                ch_reg    <= grant_idx;
                ptr_reg   <= grant_idx;
            end else if (valid_reg && i_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign o_valid   = valid_reg;
    assign o_data    = data_reg;
    assign o_ch      = ch_reg;
    assign o_pending = pending_reg;
    assign o_overrun = overrun_reg;
    assign o_armed   = armed_reg;

endmodule

// File: tb/tb_recirc_mux_rx_mc.sv
// Directed bench for recirc_mux_rx_mc: stimulus pushes expected {ch,data} beats
// into a queue, a negedge monitor pops and compares each accepted beat.
module tb_recirc_mux_rx_mc;

    localparam int NS = 2;
    localparam int W  = 8;
    localparam int N  = 4;

    logic           clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_toggle;
    logic [N*W-1:0] i_data;
    logic           o_valid;
    logic           i_ready;
    logic [W-1:0]   o_data;
    logic [1:0]     o_ch;
    logic [N-1:0]   o_pending;
    logic [N-1:0]   o_overrun;
    logic [N-1:0]   i_overrun_clr;
    logic           o_armed;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];

    recirc_mux_rx_mc #(
        .g_stages  (NS),
        .g_width   (W),
        .g_channels(N)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_toggle      (i_toggle),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_ch          (o_ch),
        .o_pending     (o_pending),
        .o_overrun     (o_overrun),
        .i_overrun_clr (i_overrun_clr),
        .o_armed       (o_armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flip(input int c, input logic [7:0] v);
        i_data[c*W +: W] = v;
        i_toggle[c]      = ~i_toggle[c];
    endtask

    task automatic expect_beat(input logic [1:0] c, input logic [7:0] v);
        exp_q.push_back({c, v});
    endtask

    // Monitor: a beat transfers at the next posedge when valid & ready
    always @(negedge clk) begin
        if (!i_rst && o_valid && i_ready) begin
            logic [9:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat_unexpected: got ch=%0d data=%0h expected none", o_ch, o_data);
            end else begin
                e = exp_q.pop_front();
                if ({o_ch, o_data} !== e) begin
                    n_err++;
                    $display("FAIL beat: got ch=%0d data=%0h expected ch=%0d data=%0h",
                             o_ch, o_data, e[9:8], e[7:0]);
                end else begin
                    $display("beat ch=%0d data=%0h", o_ch, o_data);
                end
            end
        end
    end

    initial begin
        i_rst         = 1'b1;
        i_toggle      = 4'b0101;
        i_data        = '0;
        i_ready       = 1'b1;
        i_overrun_clr = '0;
        tick(3);
        chk("rst_valid",   32'(o_valid),   0);
        chk("rst_pending", 32'(o_pending), 0);
        chk("rst_armed",   32'(o_armed),   0);
        chk("rst_overrun", 32'(o_overrun), 0);
        chk("rst_data",    32'(o_data),    0);
        chk("rst_ch",      32'(o_ch),      0);

        // Arming with toggles held static at 0101
        i_rst = 1'b0;
        tick(2);
        chk("arm_early", 32'(o_armed), 0);
        tick(2);
        chk("arm_done", 32'(o_armed), 1);
        tick(5);
        chk("static_pending", 32'(o_pending), 0);
        chk("static_valid",   32'(o_valid),   0);

        // All four channels at once: ch0..ch3 in order
        flip(0, 8'h11); flip(1, 8'h22); flip(2, 8'h33); flip(3, 8'h44);
        expect_beat(0, 8'h11); expect_beat(1, 8'h22);
        expect_beat(2, 8'h33); expect_beat(3, 8'h44);
        tick(10);
        flip(0, 8'h55); flip(3, 8'h66);
        expect_beat(0, 8'h55); expect_beat(3, 8'h66);
        tick(8);

        // Single channel latency: o_valid at E0+3
        flip(2, 8'hA5);
        expect_beat(2, 8'hA5);
        tick(3);
        chk("lat_valid_e2",   32'(o_valid),      0);
        chk("lat_pending_e2", 32'(o_pending[2]), 1);
        tick(1);
        chk("lat_valid_e3",   32'(o_valid),      1);
        tick(1);
        chk("lat_valid_drop", 32'(o_valid),      0);
        tick(3);

        // Overrun on ch1 while stalled
        i_ready = 1'b0;
        flip(1, 8'h10);
        expect_beat(1, 8'h10);
        tick(5);
        flip(1, 8'h18);
        tick(5);
        chk("ovr_pending1", 32'(o_pending[1]), 1);
        chk("ovr_pre",      32'(o_overrun[1]), 0);
        chk("stall_data",   32'(o_data),       32'h10);
        chk("stall_ch",     32'(o_ch),         1);
        flip(1, 8'h20);
        expect_beat(1, 8'h20);
        tick(5);
        chk("ovr_set",      32'(o_overrun[1]), 1);
        chk("stall_data2",  32'(o_data),       32'h10);
        chk("stall_valid",  32'(o_valid),      1);
        i_ready = 1'b1;
        tick(4);
        i_overrun_clr = 4'b0010;
        tick(1);
        i_overrun_clr = '0;
        chk("ovr_clr", 32'(o_overrun[1]), 0);

        // Set and clear in the same cycle: set wins
        i_ready = 1'b0;
        flip(3, 8'h77);
        expect_beat(3, 8'h77);
        tick(5);
        flip(3, 8'h78);
        tick(5);
        flip(3, 8'h79);
        expect_beat(3, 8'h79);
        tick(2);
        chk("ovr3_before", 32'(o_overrun[3]), 0);
        i_overrun_clr = 4'b1000;
        tick(1);
        i_overrun_clr = '0;
        chk("ovr_set_wins", 32'(o_overrun[3]), 1);
        i_ready = 1'b1;
        tick(4);
        i_overrun_clr = 4'b1000;
        tick(1);
        i_overrun_clr = '0;

        // Reset mid-operation discards output and pending words
        i_ready = 1'b0;
        flip(0, 8'hAA);
        tick(5);
        flip(1, 8'hBB); flip(2, 8'hCC);
        tick(5);
        chk("pre_rst_valid",   32'(o_valid),   1);
        chk("pre_rst_pending", 32'(o_pending), 32'h6);
        i_rst = 1'b1;
        tick(1);
        chk("mid_rst_valid",   32'(o_valid),   0);
        chk("mid_rst_pending", 32'(o_pending), 0);
        chk("mid_rst_armed",   32'(o_armed),   0);
        chk("mid_rst_data",    32'(o_data),    0);
        chk("mid_rst_ch",      32'(o_ch),      0);
        i_ready = 1'b1;
        i_rst   = 1'b0;
        tick(10);
        chk("rearm_armed",   32'(o_armed),   1);
        chk("rearm_pending", 32'(o_pending), 0);
        chk("rearm_valid",   32'(o_valid),   0);
        flip(1, 8'h5A);
        expect_beat(1, 8'h5A);
        tick(8);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
